seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver; the successor to the static per-digit hex-to-segment array.
- Latches a packed hex word, decimal-point mask and blink mask on a load strobe, then scans DIGITS digits at a programmable rate.
- Drives one shared segment bus plus per-digit anode selects. Blink timing is generated internally.
- Sits between the game/score logic and the board display pins.

Parameters:
DIGITS, 8, number of digits scanned (1..16)
SCAN_DIV, 17, prescaler width; one digit step every 2^SCAN_DIV clocks
BLINK_DIV, 24, blink phase toggles every 2^BLINK_DIV clocks
ACTIVE_LOW, 1, 1 = segments and anodes asserted low; 0 = asserted high

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
hexs  input  4*DIGITS  packed nibbles; digit i = hexs[4i+3:4i]; digit 0 is rightmost
points  input  DIGITS  decimal point on for digit i when points[i]=1
les  input  DIGITS  blink enable; digit i blanks during blink-off phase when les[i]=1
load  input  1  capture hexs/points/les into shadow registers
an  output  DIGITS  digit select, one-hot at asserted polarity
seg  output  8  {a,b,c,d,e,f,g,p} for the selected digit
digit_idx  output  clog2(DIGITS) (min 1)  index of the digit currently shown on an/seg

Behaviour:
- Reset (async assert, sync release): shadow hexs/points/les = 0; prescaler = 0; idx = 0; blink_phase = 0 (on); an = all deasserted; seg = all off; digit_idx = 0.
- Load: when load=1 at a rising edge, the shadow registers take the inputs. Inputs are ignored otherwise.
- Prescaler: free-running SCAN_DIV-bit counter. tick = counter all-ones.
- Digit index:
  - On tick, idx advances to idx+1.
  - idx wraps from DIGITS-1 to 0. It must never reach values >= DIGITS, including when DIGITS is not a power of 2.
- Blink: free-running BLINK_DIV-bit counter. blink_phase toggles when it is all-ones. Phase 1 = off.
- Output stage:
  - an, seg and digit_idx are registered every clock from the current idx and shadow values. Latency is 1 clock from idx or shadow to the pins.
  - Load-to-pin latency is therefore 2 clocks.
- Decode: standard hex glyphs 0-F.
  - Active-high segment patterns {a..g}: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - p = points[idx].
- Blanking: when les[idx]=1 and blink_phase=1, all 8 segments are off. The anode is still asserted.
- Polarity: with ACTIVE_LOW=1, seg and an are bitwise inverted at the output register. The off state is all ones.
- Simultaneous load and tick: both take effect. The next output register samples the new idx with the new shadow.
- Reset mid-scan: outputs go to the reset values immediately (asynchronously) and scanning restarts at digit 0.
- Exactly one anode is asserted at any time after the first post-reset clock.

Optional Feature:
- Macro: SEG_LZB_EN (leading-zero blanking).
- Defined: digit i>0 is blanked (segments off, dp included) when shadow nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. Blanking is computed combinationally from the shadow registers and shares the same 1-clock output latency.
- Undefined: all digits always display their glyph.

Test Plan (DIGITS=4, SCAN_DIV=2, BLINK_DIV=5, ACTIVE_LOW=1 unless noted):
- Reset held, then released -> an=4'b1111 and seg=8'hFF until the first clock; afterwards an=1110, digit_idx=0.
- load hexs=16'h12AF, points=4'b0100, les=0 -> over 16 clocks the bench sees an cycle 1110→1101→1011→0111→1110, each held 4 clocks. seg is F=~8'b10001110, A=~8'b11101110, 2 with dp=~8'b11011011, 1=~8'b01100000.
- les=4'b0001, hexs=16'h0008 -> digit 0 shows seg=8'h01 (8 with dp off) for 32 clocks, then seg=8'hFF for 32 clocks, alternating.
- Assert load with the new value 16'h5555 on the same cycle as a tick -> the very next displayed digit shows 5 (seg=~8'b10110110); no stale glyph appears.
- Pulse rst_n low for 1 ns mid-scan at idx=2 -> an=1111 and seg=FF immediately; after release the scan resumes at an=1110.
- SEG_LZB_EN defined, hexs=16'h0030 -> digits 3 and 2 are blank (seg=FF), digit 1 shows 3, digit 0 shows 0. With hexs=0, only digit 0 shows 0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with shadow registers, internal blink and polarity control.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_driver #(
  parameter  int DIGITS     = 8,
  parameter  int SCAN_DIV   = 17,
  parameter  int BLINK_DIV  = 24,
  parameter  int ACTIVE_LOW = 1,
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     les,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic [IDX_W-1:0]      digit_idx
);

  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW != 0}};
  localparam logic [7:0]        SEG_OFF = {8{ACTIVE_LOW != 0}};

  logic [4*DIGITS-1:0]  hexs_q, hexs_d;
  logic [DIGITS-1:0]    points_q, points_d;
  logic [DIGITS-1:0]    les_q, les_d;
  logic [SCAN_DIV-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BLINK_DIV-1:0] blink_cnt_q, blink_cnt_d;
  logic                 blink_phase_q, blink_phase_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic [7:0]           seg_q, seg_d;
  logic [IDX_W-1:0]     digit_idx_q, digit_idx_d;

  logic [DIGITS-1:0]    lzb;
  logic                 lz_run;
  logic [DIGITS-1:0]    an_raw;
  logic [3:0]           cur_nib;
  logic                 cur_dp, cur_le, cur_lz;
  logic [7:0]           seg_raw;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0:    hex_glyph = 7'b1111110;
      4'h1:    hex_glyph = 7'b0110000;
      4'h2:    hex_glyph = 7'b1101101;
      4'h3:    hex_glyph = 7'b1111001;
      4'h4:    hex_glyph = 7'b0110011;
      4'h5:    hex_glyph = 7'b1011011;
      4'h6:    hex_glyph = 7'b1011111;
      4'h7:    hex_glyph = 7'b1110000;
      4'h8:    hex_glyph = 7'b1111111;
      4'h9:    hex_glyph = 7'b1111011;
      4'hA:    hex_glyph = 7'b1110111;
      4'hB:    hex_glyph = 7'b0011111;
      4'hC:    hex_glyph = 7'b1001110;
      4'hD:    hex_glyph = 7'b0111101;
      4'hE:    hex_glyph = 7'b1001111;
      default: hex_glyph = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    hexs_d   = hexs_q;
    points_d = points_q;
    les_d    = les_q;
    if (load) begin
      hexs_d   = hexs;
      points_d = points;
      les_d    = les;
    end

    presc_d = presc_q + SCAN_DIV'(1);
    idx_d   = idx_q;
    // Explicit wrap keeps idx below DIGITS even when DIGITS is not a power of two.
    if (presc_q == '1)
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

    blink_cnt_d   = blink_cnt_q + BLINK_DIV'(1);
    blink_phase_d = blink_phase_q ^ (blink_cnt_q == '1);

    lzb    = '0;
    lz_run = 1'b1;
`ifdef SEG_LZB_EN
    // Walk from the most significant digit down; blank while every nibble so far is zero.
    for (int unsigned k = 0; k < DIGITS; k++) begin
      lz_run = lz_run & (hexs_q[4*(DIGITS-1-k) +: 4] == 4'h0);
      if (k != DIGITS - 1)
        lzb[DIGITS-1-k] = lz_run;
    end
`endif

    an_raw  = '0;
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_le  = 1'b0;
    cur_lz  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        an_raw[i] = 1'b1;
        cur_nib   = hexs_q[4*i +: 4];
        cur_dp    = points_q[i];
        cur_le    = les_q[i];
        cur_lz    = lzb[i];
      end
    end

    seg_raw = {hex_glyph(cur_nib), cur_dp};
    if ((cur_le && blink_phase_q) || cur_lz)
      seg_raw = '0;

    an_d        = an_raw ^ AN_OFF;
    seg_d       = seg_raw ^ SEG_OFF;
    digit_idx_d = idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hexs_q        <= '0;
      points_q      <= '0;
      les_q         <= '0;
      presc_q       <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      digit_idx_q   <= '0;
    end else begin
      hexs_q        <= hexs_d;
      points_q      <= points_d;
      les_q         <= les_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      digit_idx_q   <= digit_idx_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (DIGITS=4, SCAN_DIV=2, BLINK_DIV=5, active-low): cycle model plus literal pins.
// Leading-zero expectations follow SEG_LZB_EN when the bundle is built with it defined.
`timescale 1ns/100ps
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  les;
  logic        load;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  digit_idx;

  int tests = 0;
  int fails = 0;
  int e = 0;
  bit chk_en = 1'b0;

  seg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(2), .BLINK_DIV(5), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hexs(hexs), .points(points), .les(les),
    .load(load), .an(an), .seg(seg), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural model: n edges since reset; digit = (n/4)%4, blink = (n/32)%2.
  logic [6:0]  glyph [0:15] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  int          n = 0;
  int          mi, mph;
  logic [15:0] m_hex = '0;
  logic [3:0]  m_pts = '0, m_les = '0;
  logic [3:0]  exp_an = 4'hF;
  logic [7:0]  exp_seg = 8'hFF;
  logic [1:0]  exp_idx = '0;
  logic [7:0]  s;
  logic        blank;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_hex = '0; m_pts = '0; m_les = '0;
      exp_an = 4'hF; exp_seg = 8'hFF; exp_idx = '0;
    end else begin
      mi    = (n / 4) % 4;
      mph   = (n / 32) % 2;
      blank = m_les[mi] && (mph == 1);
`ifdef SEG_LZB_EN
      if (mi > 0 && (m_hex >> (4 * mi)) == 16'h0) blank = 1'b1;
`endif
      s       = blank ? 8'h00 : {glyph[(m_hex >> (4 * mi)) & 16'hF], m_pts[mi]};
      exp_seg = ~s;
      exp_an  = ~(4'b0001 << mi);
      exp_idx = 2'(mi);
      n++;
      if (load) begin
        m_hex = hexs; m_pts = points; m_les = les;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_an", 32'(an), 32'(exp_an));
      check("model_seg", 32'(seg), 32'(exp_seg));
      check("model_idx", 32'(digit_idx), 32'(exp_idx));
    end
  end

  task automatic goto_edge(input int target);
    while (e < target) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
    hexs = h; points = p; les = l; load = 1'b1;
    goto_edge(e + 1);
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [7:0] lz_d2, lz_d1;

  initial begin
    rst_n = 1'b1; load = 1'b0; hexs = '0; points = '0; les = '0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    #1;
    check("rel_an", 32'(an), 32'h0000_000F);
    check("rel_seg", 32'(seg), 32'h0000_00FF);
    goto_edge(1);
    check("first_an", 32'(an), 32'h0000_000E);
    check("first_idx", 32'(digit_idx), 32'h0);

    do_load(16'h12AF, 4'b0100, 4'b0000);
    goto_edge(4);  check("F_seg", 32'(seg), 32'h71); check("F_an", 32'(an), 32'hE);
    goto_edge(8);  check("A_seg", 32'(seg), 32'h11); check("A_an", 32'(an), 32'hD);
    goto_edge(12); check("2dp_seg", 32'(seg), 32'h24); check("2dp_an", 32'(an), 32'hB);
    goto_edge(16); check("1_seg", 32'(seg), 32'h9F); check("1_an", 32'(an), 32'h7);
    goto_edge(17); check("wrap_seg", 32'(seg), 32'h71); check("wrap_an", 32'(an), 32'hE);

    goto_edge(20);
    do_load(16'h0008, 4'b0000, 4'b0001);
    goto_edge(33); check("blink_off1", 32'(seg), 32'hFF); check("blink_an", 32'(an), 32'hE);
    goto_edge(65); check("blink_on", 32'(seg), 32'h01);
    goto_edge(97); check("blink_off2", 32'(seg), 32'hFF);

    // Load lands on the same edge as a scan tick (edge 100).
    goto_edge(99);
    do_load(16'h5555, 4'b0000, 4'b0000);
    goto_edge(101); check("tick_load_seg", 32'(seg), 32'h49); check("tick_load_an", 32'(an), 32'hD);

    goto_edge(106); check("pre_rst_an", 32'(an), 32'hB);
    #2 rst_n = 1'b0;
    #0.5;
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'hFF);
    check("async_idx", 32'(digit_idx), 32'h0);
    #0.5 rst_n = 1'b1;
    e = 0;
    goto_edge(1);
    check("resume_an", 32'(an), 32'hE);
    check("resume_seg", 32'(seg), 32'h03);

`ifdef SEG_LZB_EN
    lz_d2 = 8'hFF; lz_d1 = 8'hFF;
`else
    lz_d2 = 8'h03; lz_d1 = 8'h03;
`endif
    do_load(16'h0030, 4'b0000, 4'b0000);
    goto_edge(4);  check("lz_d0", 32'(seg), 32'h03);
    goto_edge(8);  check("lz_d1_3", 32'(seg), 32'h0D);
    goto_edge(12); check("lz_d2", 32'(seg), 32'(lz_d2));
    goto_edge(16); check("lz_d3", 32'(seg), 32'(lz_d2)); check("lz_d3_an", 32'(an), 32'h7);
    do_load(16'h0000, 4'b0000, 4'b0000);
    goto_edge(20); check("zero_d0", 32'(seg), 32'h03);
    goto_edge(24); check("zero_d1", 32'(seg), 32'(lz_d1));
    goto_edge(26);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
